// File: rtl/skin_box_finder.sv
// skin_box_finder: scans a stored 20x20 XYZ grid after each DONE rising edge,
// classifies each pixel as skin from its X/Y ranges, and reports the pixel
// count and the bounding box (row/col min/max) of the skin pixels.
// Optional macro SKIN_MASK_STREAM_EN adds a per-pixel skin mask stream
// (MASK_VALID/MASK_BIT/MASK_ADDR).
module skin_box_finder #(
  parameter logic [7:0] X_LO       = 8'd60,
  parameter logic [7:0] X_HI       = 8'd180,
  parameter logic [7:0] Y_LO       = 8'd50,
  parameter logic [7:0] Y_HI       = 8'd170,
  parameter logic [8:0] MIN_PIXELS = 9'd40
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       DONE,
  input  logic [7:0] X_IN,
  input  logic [7:0] Y_IN,
  input  logic [7:0] Z_IN,
  output logic       READ,
  output logic [8:0] RD_ADDR,
  output logic [4:0] ROW_MIN,
  output logic [4:0] ROW_MAX,
  output logic [4:0] COL_MIN,
  output logic [4:0] COL_MAX,
  output logic [8:0] SKIN_COUNT,
  output logic       FACE_FOUND,
  output logic       BOX_VALID,
`ifdef SKIN_MASK_STREAM_EN
  output logic       MASK_VALID,
  output logic       MASK_BIT,
  output logic [8:0] MASK_ADDR,
`endif
  output logic       BUSY
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  localparam logic [8:0] LAST_ADDR = 9'd399;
  localparam logic [4:0] LAST_COL  = 5'd19;

  // Z carries no skin information; it is deliberately ignored.
  logic unused_z;
  assign unused_z = ^Z_IN;

  logic [1:0] state_q, state_d;
  logic [8:0] addr_q, addr_d;
  logic [4:0] row_q, row_d, col_q, col_d;
  logic       done_prev_q, done_prev_d;
  logic       armed_q, armed_d;
  logic       vld_p0_q, vld_p0_d;
  logic       flag_p0_q, flag_p0_d;
  logic [4:0] frow_p0_q, frow_p0_d, fcol_p0_q, fcol_p0_d;
  logic [8:0] faddr_p0_q, faddr_p0_d;
  logic [8:0] cnt_q, cnt_d;
  logic [4:0] rmin_q, rmin_d, rmax_q, rmax_d, cmin_q, cmin_d, cmax_q, cmax_d;
  logic [4:0] out_rmin_q, out_rmin_d, out_rmax_q, out_rmax_d;
  logic [4:0] out_cmin_q, out_cmin_d, out_cmax_q, out_cmax_d;
  logic [8:0] out_cnt_q, out_cnt_d;
  logic       face_q, face_d;
  logic       box_valid_q, box_valid_d;
  logic       skin;

  function automatic logic is_skin(input logic [7:0] x, input logic [7:0] y);
    is_skin = (x >= X_LO) && (x <= X_HI) && (y >= Y_LO) && (y <= Y_HI);
  endfunction

  assign skin = is_skin(X_IN, Y_IN);

  // Next-state: scan sequencing, pixel classification, accumulation, report load.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    row_d       = row_q;
    col_d       = col_q;
    done_prev_d = DONE;
    // A scan may only start once DONE has been seen low since reset.
    armed_d     = armed_q | ~DONE;
    vld_p0_d    = 1'b0;
    flag_p0_d   = 1'b0;
    frow_p0_d   = frow_p0_q;
    fcol_p0_d   = fcol_p0_q;
    faddr_p0_d  = faddr_p0_q;
    cnt_d       = cnt_q;
    rmin_d      = rmin_q;
    rmax_d      = rmax_q;
    cmin_d      = cmin_q;
    cmax_d      = cmax_q;
    out_rmin_d  = out_rmin_q;
    out_rmax_d  = out_rmax_q;
    out_cmin_d  = out_cmin_q;
    out_cmax_d  = out_cmax_q;
    out_cnt_d   = out_cnt_q;
    face_d      = face_q;
    box_valid_d = 1'b0;

    // Registered flag from the previous edge feeds the accumulators.
    if (vld_p0_q && flag_p0_q) begin
      cnt_d = cnt_q + 9'd1;
      if (frow_p0_q < rmin_q) rmin_d = frow_p0_q;
      if (frow_p0_q > rmax_q) rmax_d = frow_p0_q;
      if (fcol_p0_q < cmin_q) cmin_d = fcol_p0_q;
      if (fcol_p0_q > cmax_q) cmax_d = fcol_p0_q;
    end

    case (state_q)
      S_IDLE: begin
        if (DONE && !done_prev_q && armed_q) begin
          state_d = S_SCAN;
          addr_d  = 9'd0;
          row_d   = 5'd0;
          col_d   = 5'd0;
          cnt_d   = 9'd0;
          rmin_d  = 5'd31;
          rmax_d  = 5'd0;
          cmin_d  = 5'd31;
          cmax_d  = 5'd0;
        end
      end
      S_SCAN: begin
        vld_p0_d   = 1'b1;
        flag_p0_d  = skin;
        frow_p0_d  = row_q;
        fcol_p0_d  = col_q;
        faddr_p0_d = addr_q;
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          addr_d  = 9'd0;
          row_d   = 5'd0;
          col_d   = 5'd0;
        end else begin
          addr_d = addr_q + 9'd1;
          if (col_q == LAST_COL) begin
            col_d = 5'd0;
            row_d = row_q + 5'd1;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_REPORT;
      end
      default: begin
        state_d     = S_IDLE;
        box_valid_d = 1'b1;
        out_cnt_d   = cnt_q;
        face_d      = (cnt_q != 9'd0) && (cnt_q >= MIN_PIXELS);
        if (cnt_q == 9'd0) begin
          out_rmin_d = 5'd0;
          out_rmax_d = 5'd0;
          out_cmin_d = 5'd0;
          out_cmax_d = 5'd0;
        end else begin
          out_rmin_d = rmin_q;
          out_rmax_d = rmax_q;
          out_cmin_d = cmin_q;
          out_cmax_d = cmax_q;
        end
      end
    endcase
  end

  // Control and reported state, cleared by RESET.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      addr_q      <= 9'd0;
      row_q       <= 5'd0;
      col_q       <= 5'd0;
      done_prev_q <= 1'b0;
      armed_q     <= ~DONE;
      vld_p0_q    <= 1'b0;
      cnt_q       <= 9'd0;
      rmin_q      <= 5'd31;
      rmax_q      <= 5'd0;
      cmin_q      <= 5'd31;
      cmax_q      <= 5'd0;
      out_rmin_q  <= 5'd0;
      out_rmax_q  <= 5'd0;
      out_cmin_q  <= 5'd0;
      out_cmax_q  <= 5'd0;
      out_cnt_q   <= 9'd0;
      face_q      <= 1'b0;
      box_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      row_q       <= row_d;
      col_q       <= col_d;
      done_prev_q <= done_prev_d;
      armed_q     <= armed_d;
      vld_p0_q    <= vld_p0_d;
      cnt_q       <= cnt_d;
      rmin_q      <= rmin_d;
      rmax_q      <= rmax_d;
      cmin_q      <= cmin_d;
      cmax_q      <= cmax_d;
      out_rmin_q  <= out_rmin_d;
      out_rmax_q  <= out_rmax_d;
      out_cmin_q  <= out_cmin_d;
      out_cmax_q  <= out_cmax_d;
      out_cnt_q   <= out_cnt_d;
      face_q      <= face_d;
      box_valid_q <= box_valid_d;
    end
  end

  // Stage p0: classified pixel and its coordinates (qualified by vld_p0_q).
  always_ff @(posedge CLK) begin
    flag_p0_q  <= flag_p0_d;
    frow_p0_q  <= frow_p0_d;
    fcol_p0_q  <= fcol_p0_d;
    faddr_p0_q <= faddr_p0_d;
  end

  assign READ       = (state_q == S_SCAN);
  assign RD_ADDR    = addr_q;
  assign BUSY       = (state_q != S_IDLE);
  assign ROW_MIN    = out_rmin_q;
  assign ROW_MAX    = out_rmax_q;
  assign COL_MIN    = out_cmin_q;
  assign COL_MAX    = out_cmax_q;
  assign SKIN_COUNT = out_cnt_q;
  assign FACE_FOUND = face_q;
  assign BOX_VALID  = box_valid_q;

`ifdef SKIN_MASK_STREAM_EN
  assign MASK_VALID = vld_p0_q;
  assign MASK_BIT   = flag_p0_q;
  assign MASK_ADDR  = faddr_p0_q;
`else
  logic unused_faddr;
  assign unused_faddr = ^faddr_p0_q;
`endif

endmodule

// File: tb/tb_skin_box_finder.sv
// Directed bench for skin_box_finder: fixed grid contents, hand-computed
// counts/boxes, latency and DONE/RESET edge cases.
module tb_skin_box_finder;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       DONE = 1'b0;
  logic [7:0] X_IN, Y_IN, Z_IN;
  logic       READ;
  logic [8:0] RD_ADDR;
  logic [4:0] ROW_MIN, ROW_MAX, COL_MIN, COL_MAX;
  logic [8:0] SKIN_COUNT;
  logic       FACE_FOUND, BOX_VALID, BUSY;
`ifdef SKIN_MASK_STREAM_EN
  logic       MASK_VALID, MASK_BIT;
  logic [8:0] MASK_ADDR;
`endif

  logic [7:0] xm [400];
  logic [7:0] ym [400];

  int total = 0;
  int bad = 0;
  int lat;
  int p;

  always #5 CLK = ~CLK;

  assign X_IN = xm[RD_ADDR];
  assign Y_IN = ym[RD_ADDR];
  assign Z_IN = 8'hA5;

  skin_box_finder dut (
    .CLK(CLK), .RESET(RESET), .DONE(DONE),
    .X_IN(X_IN), .Y_IN(Y_IN), .Z_IN(Z_IN),
    .READ(READ), .RD_ADDR(RD_ADDR),
    .ROW_MIN(ROW_MIN), .ROW_MAX(ROW_MAX), .COL_MIN(COL_MIN), .COL_MAX(COL_MAX),
    .SKIN_COUNT(SKIN_COUNT), .FACE_FOUND(FACE_FOUND), .BOX_VALID(BOX_VALID),
`ifdef SKIN_MASK_STREAM_EN
    .MASK_VALID(MASK_VALID), .MASK_BIT(MASK_BIT), .MASK_ADDR(MASK_ADDR),
`endif
    .BUSY(BUSY)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] x, input logic [7:0] y);
    for (int i = 0; i < 400; i++) begin
      xm[i] = x;
      ym[i] = y;
    end
  endtask

  // Rising DONE, then wait (bounded) for BOX_VALID; lat = edges after the start edge.
  task automatic run_scan(input string tag, output int latency);
    @(negedge CLK); DONE = 1'b0;
    @(negedge CLK); DONE = 1'b1;
    @(posedge CLK); #1;
    check({tag, "_read0"}, READ, 1);
    check({tag, "_addr0"}, RD_ADDR, 0);
    check({tag, "_busy0"}, BUSY, 1);
    DONE = 1'b0;
    latency = -1;
    for (int n = 1; n <= 600; n++) begin
      @(posedge CLK); #1;
      if (n == 1) check({tag, "_addr1"}, RD_ADDR, 1);
      if (n == 400) begin
        check({tag, "_drain_read"}, READ, 0);
        check({tag, "_drain_busy"}, BUSY, 1);
      end
      if (BOX_VALID) begin
        latency = n;
        break;
      end
    end
    check({tag, "_latency"}, latency, 402);
    @(posedge CLK); #1;
    check({tag, "_bv_one_cycle"}, BOX_VALID, 0);
    check({tag, "_busy_idle"}, BUSY, 0);
  endtask

  task automatic check_box(input string tag, input int cnt, input int rmin, input int rmax,
                           input int cmin, input int cmax, input int face);
    check({tag, "_count"}, SKIN_COUNT, cnt);
    check({tag, "_rmin"}, ROW_MIN, rmin);
    check({tag, "_rmax"}, ROW_MAX, rmax);
    check({tag, "_cmin"}, COL_MIN, cmin);
    check({tag, "_cmax"}, COL_MAX, cmax);
    check({tag, "_face"}, FACE_FOUND, face);
  endtask

  task automatic count_pulses(input int ncyc, output int pulses);
    pulses = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge CLK); #1;
      if (BOX_VALID) pulses++;
    end
  endtask

  initial begin
    fill(8'd0, 8'd0);
    repeat (3) @(posedge CLK);
    #1;
    check("rst_read", READ, 0);
    check("rst_addr", RD_ADDR, 0);
    check("rst_busy", BUSY, 0);
    check("rst_bv", BOX_VALID, 0);
    check_box("rst", 0, 0, 0, 0, 0, 0);
    @(negedge CLK); RESET = 1'b0;

    // Whole grid skin.
    fill(8'd100, 8'd100);
    run_scan("all", lat);
    check_box("all", 400, 0, 19, 0, 19, 1);

    // No skin at all.
    fill(8'd0, 8'd100);
    run_scan("none", lat);
    check_box("none", 0, 0, 0, 0, 0, 0);

    // Block rows 5..9, cols 3..10 = 40 pixels.
    fill(8'd0, 8'd0);
    for (int r = 5; r <= 9; r++)
      for (int c = 3; c <= 10; c++) begin
        xm[r*20+c] = 8'd120;
        ym[r*20+c] = 8'd90;
      end
    run_scan("blk40", lat);
    check_box("blk40", 40, 5, 9, 3, 10, 1);

    // Drop one pixel: 39 -> no face.
    xm[9*20+10] = 8'd0;
    run_scan("blk39", lat);
    check_box("blk39", 39, 5, 9, 3, 10, 0);

    // Range boundaries and last address.
    fill(8'd0, 8'd0);
    xm[0] = 8'd181; ym[0] = 8'd100;
    xm[21] = 8'd59; ym[21] = 8'd100;
    xm[22] = 8'd100; ym[22] = 8'd171;
    xm[399] = 8'd60; ym[399] = 8'd170;
    run_scan("edge", lat);
    check_box("edge", 1, 19, 19, 19, 19, 0);

    // DONE held high for 1000 cycles: one scan only.
    fill(8'd100, 8'd100);
    @(negedge CLK); DONE = 1'b0;
    @(negedge CLK); DONE = 1'b1;
    count_pulses(1000, p);
    check("held_pulses", p, 1);
    check_box("held", 400, 0, 19, 0, 19, 1);
    DONE = 1'b0;

    // DONE pulsed mid-scan is ignored.
    fill(8'd0, 8'd0);
    xm[0] = 8'd100; ym[0] = 8'd100;
    @(negedge CLK); DONE = 1'b1;
    @(posedge CLK); #1;
    DONE = 1'b0;
    repeat (199) begin @(posedge CLK); #1; end
    DONE = 1'b1;
    @(posedge CLK); #1;
    DONE = 1'b0;
    count_pulses(900, p);
    check("midpulse_pulses", p, 1);
    check_box("midpulse", 1, 0, 0, 0, 0, 0);

    // Reset mid-scan with DONE still high.
    fill(8'd100, 8'd100);
    @(negedge CLK); DONE = 1'b1;
    @(posedge CLK); #1;
    count_pulses(149, p);
    check("rstmid_before", p, 0);
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); #1;
    check("rstmid_read", READ, 0);
    check("rstmid_addr", RD_ADDR, 0);
    check("rstmid_busy", BUSY, 0);
    check("rstmid_count", SKIN_COUNT, 0);
    @(negedge CLK); RESET = 1'b0;
    count_pulses(500, p);
    check("rstmid_no_restart", p, 0);
    check("rstmid_idle", BUSY, 0);
    run_scan("after_rst", lat);
    check_box("after_rst", 400, 0, 19, 0, 19, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/skin_box_finder.md
SKIN_BOX_FINDER -- requirements
Module: skin_box_finder

Interface
REQ-001 The block SHALL have parameter X_LO, default 8'd60, lower inclusive bound on X for a skin pixel.
REQ-002 The block SHALL have parameter X_HI, default 8'd180, upper inclusive bound on X.
REQ-003 The block SHALL have parameter Y_LO, default 8'd50, lower inclusive bound on Y.
REQ-004 The block SHALL have parameter Y_HI, default 8'd170, upper inclusive bound on Y.
REQ-005 The block SHALL have parameter MIN_PIXELS, default 9'd40, minimum skin count for a face.
REQ-006 The block SHALL have port CLK, input, 1, the single system clock.
REQ-007 The block SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port DONE, input, 1, level from the scaler indicating a complete 20x20 XYZ grid is stored.
REQ-009 The block SHALL have ports X_IN, Y_IN, Z_IN, input, 8 each, pixel data returned combinationally for RD_ADDR.
REQ-010 The block SHALL have port READ, output, 1, read enable to the scaler.
REQ-011 The block SHALL have port RD_ADDR, output, 9, grid address 0..399, row-major (addr = row*20 + col).
REQ-012 The block SHALL have ports ROW_MIN, ROW_MAX, COL_MIN, COL_MAX, output, 5 each, skin bounding box.
REQ-013 The block SHALL have port SKIN_COUNT, output, 9, number of skin pixels in the last scan.
REQ-014 The block SHALL have ports FACE_FOUND, BOX_VALID, BUSY, output, 1 each.

Function
REQ-015 The FSM SHALL have states IDLE, SCAN, DRAIN, REPORT.
REQ-016 IDLE SHALL move to SCAN on the edge that samples a DONE rising edge (DONE=1, previous DONE=0); a DONE held high SHALL NOT retrigger.
REQ-017 On entering SCAN, RD_ADDR SHALL be 0 and READ 1; RD_ADDR SHALL increment by 1 per cycle through 399.
REQ-018 Row/col SHALL be tracked by counters (col 0..19 wraps to 0 with row+1); no divider.
REQ-019 Each edge in SCAN SHALL register skin flag = (X_LO<=X_IN<=X_HI) AND (Y_LO<=Y_IN<=Y_HI) plus its row/col; Z_IN SHALL be ignored.
REQ-020 The registered flag SHALL update accumulators one edge later: count+1, min/max row/col updated.
REQ-021 After sampling RD_ADDR 399, the FSM SHALL enter DRAIN for 1 cycle with READ=0, then REPORT for 1 cycle, then IDLE.
REQ-022 On entering REPORT, outputs SHALL load from the accumulators; BOX_VALID SHALL be 1 for exactly the REPORT cycle.
REQ-023 Latency: BOX_VALID SHALL assert 402 edges after the DONE-rise sampling edge.
REQ-024 FACE_FOUND SHALL equal (SKIN_COUNT >= MIN_PIXELS), registered with the box outputs.
REQ-025 If the count is 0, box outputs SHALL be all 0 and FACE_FOUND 0.
REQ-026 Box outputs, SKIN_COUNT and FACE_FOUND SHALL hold until the next REPORT.
REQ-027 BUSY SHALL be 1 in SCAN, DRAIN, REPORT; 0 in IDLE.
REQ-028 DONE rising during SCAN/DRAIN/REPORT SHALL be ignored (no queueing).
REQ-029 Accumulators SHALL clear (min=31, max=0, count=0) on entering SCAN.
REQ-030 READ SHALL be 0 and RD_ADDR 0 outside SCAN.

Reset
REQ-031 RESET SHALL, on the clock edge, force IDLE, READ=0, RD_ADDR=0, BOX_VALID=0, BUSY=0, all box/count outputs 0, FACE_FOUND=0, DONE-history 0.
REQ-032 RESET mid-scan SHALL abort without BOX_VALID; a DONE still high after reset SHALL NOT start a scan until it falls and rises again.

Configuration
REQ-033 With macro SKIN_MASK_STREAM_EN defined, ports MASK_VALID (1), MASK_BIT (1), MASK_ADDR (9) SHALL exist, emitting the registered flag and its address each cycle one edge after sampling (400 pulses per scan).
REQ-034 Without SKIN_MASK_STREAM_EN, those ports and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-035 All pixels X=100,Y=100 -> SKIN_COUNT=400, box (0,19,0,19), FACE_FOUND=1, BOX_VALID one cycle at edge 402.
REQ-036 All pixels X=0 -> SKIN_COUNT=0, box all 0, FACE_FOUND=0.
REQ-037 Skin only at rows 5..9, cols 3..10 -> count 40, ROW_MIN=5, ROW_MAX=9, COL_MIN=3, COL_MAX=10, FACE_FOUND=1; 39 pixels -> FACE_FOUND=0.
REQ-038 Boundary: X=60,Y=170 counted as skin; X=181 not; single skin pixel at addr 399 -> box (19,19,19,19).
REQ-039 DONE held high 1000 cycles -> exactly one scan; DONE pulsed at scan cycle 200 -> ignored.
REQ-040 RESET at scan cycle 150 -> READ=0 next cycle, no BOX_VALID, outputs 0; new DONE rise -> full scan from addr 0.
